// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Contains the FSM state encoding, requester port identifiers and counter width.
// Imported by the arbiter top and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side handshake signals for mem_port_arbiter.
// slave modport is the arbiter's view; master modport is the environment's view.
// Widths follow the DATA_W/ADDR_W parameters and must match the arbiter instance.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // Port 0 (instruction fetch)
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;
  logic [DATA_W-1:0] rdata0;
  // Port 1 (data access)
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;
  logic [DATA_W-1:0] rdata1;
  // Ownership status
  logic              grant;
  logic              busy;
  // Memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output done0, rdata0,
    input  req1, we1, addr1, wdata1,
    output done1, rdata1,
    output grant, busy,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  done0, rdata0,
    output req1, we1, addr1, wdata1,
    input  done1, rdata1,
    input  grant, busy,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: chooses the requester that did not win last.
// Latency: zero cycles (pure combinational).
// No backpressure; valid is simply "any request present".
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_pick
);

  // On a tie the port that did not win last time goes next; otherwise the lone requester.
  always_comb begin
    o_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_pick = ~i_last;
    end else if (i_req1) begin
      o_pick = PORT_DATA;
    end else begin
      o_pick = PORT_IFETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between ifetch (port 0) and data (port 1).
// Latency: req seen in IDLE -> mem_req next cycle; mem_ack -> done pulse next cycle.
// Requesters hold req until done; memory fields are frozen at grant until mem_ack.
// Optional grant counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_port_arbiter_if.slave  io_bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] o_gnt_cnt0,
  output logic [PERF_CNT_W-1:0] o_gnt_cnt1
`endif
);

  arb_state_t        r_state,     w_state_nxt;
  logic              r_last,      w_last_nxt;
  logic              r_grant,     w_grant_nxt;
  logic              r_busy,      w_busy_nxt;
  logic              r_mem_req,   w_mem_req_nxt;
  logic              r_mem_we,    w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_done0,     w_done0_nxt;
  logic              r_done1,     w_done1_nxt;
  logic [DATA_W-1:0] r_rdata0,    w_rdata0_nxt;
  logic [DATA_W-1:0] r_rdata1,    w_rdata1_nxt;

  logic w_pick_vld;
  logic w_pick;
  logic w_grant_evt;

  rr_pick2 u_pick (
    .i_req0  (io_bus.req0),
    .i_req1  (io_bus.req1),
    .i_last  (r_last),
    .o_valid (w_pick_vld),
    .o_pick  (w_pick)
  );

  assign w_grant_evt = (r_state == IDLE) && w_pick_vld;

  // State and output registers; reset drops everything, including any in-flight access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_last      <= PORT_DATA;
      r_grant     <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_grant     <= w_grant_nxt;
      r_busy      <= w_busy_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_done0     <= w_done0_nxt;
      r_done1     <= w_done1_nxt;
      r_rdata0    <= w_rdata0_nxt;
      r_rdata1    <= w_rdata1_nxt;
    end
  end

  // Next-state and next-output logic; done defaults low so it can only pulse for one cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_grant_nxt     = r_grant;
    w_busy_nxt      = r_busy;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_done0_nxt     = 1'b0;
    w_done1_nxt     = 1'b0;
    w_rdata0_nxt    = r_rdata0;
    w_rdata1_nxt    = r_rdata1;

    case (r_state)
      IDLE: begin
        // mem_ack here is stale or spurious and is deliberately ignored.
        if (w_pick_vld) begin
          w_grant_nxt     = w_pick;
          w_last_nxt      = w_pick;
          w_busy_nxt      = 1'b1;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = (w_pick == PORT_DATA) ? io_bus.we1    : io_bus.we0;
          w_mem_addr_nxt  = (w_pick == PORT_DATA) ? io_bus.addr1  : io_bus.addr0;
          w_mem_wdata_nxt = (w_pick == PORT_DATA) ? io_bus.wdata1 : io_bus.wdata0;
          w_state_nxt     = BUSY;
        end
      end
      BUSY: begin
        // Requests may drop here; the access still runs to completion.
        if (io_bus.mem_ack) begin
          w_mem_req_nxt = 1'b0;
          if (r_grant == PORT_DATA) begin
            w_rdata1_nxt = io_bus.mem_rdata;
            w_done1_nxt  = 1'b1;
          end else begin
            w_rdata0_nxt = io_bus.mem_rdata;
            w_done0_nxt  = 1'b1;
          end
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Requests are not considered here; re-arbitration waits for IDLE.
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_busy_nxt    = 1'b0;
        w_mem_req_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  assign io_bus.done0     = r_done0;
  assign io_bus.done1     = r_done1;
  assign io_bus.rdata0    = r_rdata0;
  assign io_bus.rdata1    = r_rdata1;
  assign io_bus.grant     = r_grant;
  assign io_bus.busy      = r_busy;
  assign io_bus.mem_req   = r_mem_req;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;

`ifdef ARB_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] r_gnt_cnt0;
  logic [PERF_CNT_W-1:0] r_gnt_cnt1;

  // Per-port grant counters, saturating so a long run never wraps back to a small value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else if (w_grant_evt) begin
      if ((w_pick == PORT_IFETCH) && (r_gnt_cnt0 != '1)) begin
        r_gnt_cnt0 <= r_gnt_cnt0 + 1'b1;
      end
      if ((w_pick == PORT_DATA) && (r_gnt_cnt1 != '1)) begin
        r_gnt_cnt1 <= r_gnt_cnt1 + 1'b1;
      end
    end
  end

  assign o_gnt_cnt0 = r_gnt_cnt0;
  assign o_gnt_cnt1 = r_gnt_cnt1;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 32-bit memory port between instruction fetch (port 0) and data access (port 1).
- Sits between the CPU datapath and the unified memory.
- Drives the 32-bit address/data selection that picks which requester owns the port.
- Sequences each access through a request/acknowledge handshake and returns read data to the owning requester.

Parameters:
- DATA_W, 32, width of write/read data buses
- ADDR_W, 32, width of address buses

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req0  in  1  port-0 access request, level; held until done0
- we0  in  1  port-0 write enable (1 = write, 0 = read)
- addr0  in  ADDR_W  port-0 address
- wdata0  in  DATA_W  port-0 write data
- done0  out  1  one-cycle pulse: port-0 access complete
- rdata0  out  DATA_W  port-0 read data, valid while done0=1
- req1, we1, addr1, wdata1, done1, rdata1: same as port 0, for port 1
- grant  out  1  current owner (0 = port 0, 1 = port 1), valid while busy
- busy  out  1  a transaction is outstanding
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - All outputs = 0.
  - State = IDLE.
  - Round-robin pointer last = 1, so port 0 wins the first tie.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If only one request is high, grant that port.
  - If both are high, grant port (~last).
  - On grant: register grant, and register mem_we/mem_addr/mem_wdata from the granted port via 32-bit 2:1 selection. Set mem_req=1, busy=1, last=granted port, next state = BUSY.
  - Latency: req sampled high in cycle n gives mem_req=1 in cycle n+1.
- BUSY:
  - Hold mem_req and all mem_* fields stable until mem_ack.
  - When mem_ack=1 in cycle m:
    - mem_req=0 from cycle m+1.
    - Capture mem_rdata into rdata of the granted port (for writes too; requester ignores it).
    - Next state = DONE.
- DONE:
  - done of the granted port = 1 for exactly this cycle (m+1); the other port's done stays 0.
  - busy=0 at the next edge; next state = IDLE.
  - A request still high in DONE is not considered; re-arbitration happens in IDLE at m+2, so the earliest next mem_req is m+3.
- Requester protocol: each requester must drop req the cycle after its done. A req still high in the following IDLE is treated as a new request.
- rdata registers hold their value between accesses. They are reset to 0.
- Boundary conditions:
  - mem_ack while IDLE or DONE: ignored.
  - req dropped during BUSY: the transaction still completes and done still pulses.
  - Address/data changes during BUSY: ignored, because the memory fields were registered at grant.
  - rst mid-transaction (any state): outputs 0 and state IDLE at the next edge. No done is generated. A late mem_ack arriving after reset is ignored.
  - Fairness: under continuous requests from both ports, grants alternate 0,1,0,1 and neither port waits more than one transaction.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1, 16 bits each.
  - Each increments on every grant to its port and saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: the ports and counters do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg contains:
  - State enum with IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Constants PORT_IFETCH=1'b0 and PORT_DATA=1'b1.
  - Counter width constant PERF_CNT_W=16.
- One natural sub-module: rr_pick2, a combinational round-robin picker.
  - Inputs: req0, req1, last.
  - Outputs: valid and pick.
  - Instantiated once.

Test Plan:
- Reset, then req0=1, we0=0, addr0=32'h0000_0040 -> mem_req=1 one cycle later with mem_addr=32'h40, mem_we=0, grant=0; mem_ack with mem_rdata=32'hDEADBEEF -> done0 pulses for one cycle with rdata0=32'hDEADBEEF; done1 stays 0.
- req0 and req1 asserted together from reset, mem_ack 2 cycles after each mem_req -> grant order 0,1,0,1 over four transactions; each done pulses exactly once per grant.
- Port-1 write with we1=1, addr1=32'h100, wdata1=32'h12345678, then addr1/wdata1 changed during BUSY -> mem_addr and mem_wdata stay 32'h100 / 32'h12345678 until mem_ack.
- rst asserted in the BUSY cycle before mem_ack -> next cycle mem_req=0, busy=0, no done; a mem_ack pulse after reset produces no done; a subsequent req1 is granted normally.
- Spurious mem_ack in IDLE with no requests -> no done pulse, state stays IDLE, rdata0/rdata1 unchanged.
- With ARB_PERF_CNT_EN defined: 3 port-0 and 2 port-1 transactions -> gnt_cnt0=3, gnt_cnt1=2. With the counter forced to 16'hFFFF, one more grant leaves it at 16'hFFFF.
